// File: rtl/timer_arbiter_pkg.sv
// Shared types and default sizes for the timer arbiter and its selector.
package timer_arbiter_pkg;

   localparam int NREQ_DEF  = 2;
   localparam int CNT_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/timer_arbiter_rr_pick.sv
// Round-robin selector: first set request at or above ptr, wrapping to 0.
module rr_pick
   import timer_arbiter_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   localparam int IDX_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic [NREQ-1:0]  grant,
   output logic [IDX_W-1:0] idx
);

   logic             found;
   logic [IDX_W-1:0] cand;
   logic [IDX_W-1:0] idx_sel;

   // Scan from ptr upward with wrap; the first requester seen wins.
   always_comb begin
      found   = 1'b0;
      cand    = '0;
      idx_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = IDX_W'((int'(ptr) + i) % NREQ);
         if (!found && req[cand]) begin
            found   = 1'b1;
            idx_sel = cand;
         end
      end
   end

   assign idx = idx_sel;

   // One-hot decode of the winning index; all zero when nobody requests.
   for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant
      assign grant[gi] = found && (idx_sel == IDX_W'(gi));
   end

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin arbiter in front of one shared down-counter: a winning
// requester gets an ack pulse, then a done pulse exactly dly cycles later.
module timer_arbiter
   import timer_arbiter_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int NREQ  = NREQ_DEF
) (
   input  logic                  clk_in,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*CNT_W-1:0] dly,
   input  logic                  cancel,
   output logic [NREQ-1:0]       ack,
   output logic [NREQ-1:0]       done,
   output logic                  busy
);

   localparam int IDX_W = $clog2(NREQ);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic             hold_q, hold_d;
   logic [NREQ-1:0]  ack_q, ack_d;
   logic [NREQ-1:0]  done_q, done_d;
   logic             busy_q, busy_d;

   logic [NREQ-1:0]  owner_oh;
   logic [NREQ-1:0]  req_avail;
   logic [NREQ-1:0]  pick_grant;
   logic [IDX_W-1:0] pick_idx;
   logic [CNT_W-1:0] dly_pick;
   logic [IDX_W-1:0] owner_next;

   // hold_q marks that the last owner has kept its req high since its
   // grant; that owner is hidden from the selector until it lets go.
   assign owner_oh   = NREQ'(1) << owner_q;
   assign req_avail  = req & ~(hold_q ? owner_oh : '0);
   assign dly_pick   = dly[int'(pick_idx)*CNT_W +: CNT_W];
   assign owner_next = (owner_q == IDX_W'(NREQ-1)) ? '0 : owner_q + 1'b1;

   rr_pick #(
      .NREQ (NREQ)
   ) u_rr_pick (
      .req   (req_avail),
      .ptr   (ptr_q),
      .grant (pick_grant),
      .idx   (pick_idx)
   );

   // Next-state, counter and registered-output computation.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q && req[owner_q];
      ack_d   = '0;
      done_d  = '0;
      case (state_q)
         IDLE: begin
            if (|req_avail) begin
               state_d = COUNT;
               // A zero delay behaves as one cycle so done still follows ack.
               cnt_d   = (dly_pick == '0) ? CNT_W'(1) : dly_pick;
               owner_d = pick_idx;
               ack_d   = pick_grant;
               hold_d  = 1'b1;
            end
         end
         COUNT: begin
            // cancel outranks expiry, including the cnt==1 cycle.
            if (cancel) begin
               state_d = IDLE;
               ptr_d   = owner_next;
            end else if (cnt_q == CNT_W'(1)) begin
               state_d = DONE;
               cnt_d   = '0;
               done_d  = owner_oh;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
            ptr_d   = owner_next;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and output registers, cleared immediately by reset.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         owner_q <= '0;
         ptr_q   <= '0;
         hold_q  <= 1'b0;
         ack_q   <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign ack  = ack_q;
   assign done = done_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench: stimulus pushes expected ack/done events with their cycle
// numbers; a negedge monitor pops and compares whenever ack or done fires.
module tb_timer_arbiter;

   localparam int CNT_W = 8;
   localparam int NREQ  = 2;

   logic                  clk_in = 1'b0;
   logic                  reset;
   logic [NREQ-1:0]       req;
   logic [NREQ*CNT_W-1:0] dly;
   logic                  cancel;
   logic [NREQ-1:0]       ack;
   logic [NREQ-1:0]       done;
   logic                  busy;

   typedef struct {
      bit         is_done;
      logic [1:0] vec;
      int         cyc;
   } ev_t;

   ev_t exp_q[$];
   ev_t mon_e;
   int  cyc   = 0;
   int  total = 0;
   int  bad   = 0;
   int  t;

   timer_arbiter #(
      .CNT_W (CNT_W),
      .NREQ  (NREQ)
   ) dut (
      .clk_in (clk_in),
      .reset  (reset),
      .req    (req),
      .dly    (dly),
      .cancel (cancel),
      .ack    (ack),
      .done   (done),
      .busy   (busy)
   );

   always #5 clk_in = ~clk_in;

   // Cycle index: after posedge N the bench is in cycle N.
   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   task automatic push(input bit d, input logic [1:0] v, input int c);
      ev_t e;
      e.is_done = d;
      e.vec     = v;
      e.cyc     = c;
      exp_q.push_back(e);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   task automatic set_dly(input int d0, input int d1);
      dly = {CNT_W'(d1), CNT_W'(d0)};
   endtask

   // Scoreboard monitor.
   always @(negedge clk_in) begin
      if (!reset && (ack !== 2'b00 || done !== 2'b00)) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_event", {28'd0, ack, done}, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.is_done) begin
               chk("done_vec", {30'd0, done}, {30'd0, mon_e.vec});
               chk("ack_quiet_at_done", {30'd0, ack}, 32'd0);
            end else begin
               chk("ack_vec", {30'd0, ack}, {30'd0, mon_e.vec});
               chk("done_quiet_at_ack", {30'd0, done}, 32'd0);
            end
            chk("event_cycle", cyc, mon_e.cyc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      reset  = 1'b1;
      req    = '0;
      cancel = 1'b0;
      set_dly(0, 0);
      tick(2);
      chk("reset_ack", {30'd0, ack}, 32'd0);
      chk("reset_done", {30'd0, done}, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      reset = 1'b0;
      tick(2);

      // Contention: grants 0,1,0 with dly0=3, dly1=4.
      t = cyc;
      req = 2'b11;
      set_dly(3, 4);
      push(0, 2'b01, t + 1);
      push(1, 2'b01, t + 4);
      push(0, 2'b10, t + 6);
      push(1, 2'b10, t + 10);
      push(0, 2'b01, t + 12);
      push(1, 2'b01, t + 15);
      tick(12);
      req = 2'b00;
      tick(4);
      chk("contention_idle_busy", {31'd0, busy}, 32'd0);

      // Single request, dly0=5; late dly change and a short-lived req1.
      tick();
      t = cyc;
      req = 2'b01;
      set_dly(5, 9);
      push(0, 2'b01, t + 1);
      push(1, 2'b01, t + 6);
      tick();
      chk("single_busy_first", {31'd0, busy}, 32'd1);
      req = 2'b00;
      set_dly(200, 200);
      tick();
      req = 2'b10;
      tick();
      req = 2'b00;
      tick(3);
      chk("single_busy_last", {31'd0, busy}, 32'd1);
      tick();
      chk("single_busy_after", {31'd0, busy}, 32'd0);
      tick();

      // Zero delay behaves as one cycle.
      t = cyc;
      req = 2'b01;
      set_dly(0, 0);
      push(0, 2'b01, t + 1);
      push(1, 2'b01, t + 2);
      tick();
      req = 2'b00;
      tick();
      chk("zero_busy_done", {31'd0, busy}, 32'd1);
      tick();
      chk("zero_busy_after", {31'd0, busy}, 32'd0);
      tick();

      // Cancel at ack+4; cancel held into IDLE must not block the next grant.
      t = cyc;
      req = 2'b01;
      set_dly(10, 2);
      push(0, 2'b01, t + 1);
      tick();
      req = 2'b00;
      tick(4);
      chk("cancel_busy_before", {31'd0, busy}, 32'd1);
      cancel = 1'b1;
      tick();
      chk("cancel_busy_after", {31'd0, busy}, 32'd0);
      req = 2'b11;
      push(0, 2'b10, t + 7);
      push(1, 2'b10, t + 9);
      tick();
      cancel = 1'b0;
      req = 2'b00;
      tick(2);
      chk("post_cancel_busy", {31'd0, busy}, 32'd1);
      tick();
      chk("post_cancel_idle", {31'd0, busy}, 32'd0);
      tick();

      // Cancel in the cnt==1 cycle wins over expiry.
      t = cyc;
      req = 2'b01;
      set_dly(3, 0);
      push(0, 2'b01, t + 1);
      tick();
      req = 2'b00;
      tick(2);
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      chk("collision_busy", {31'd0, busy}, 32'd0);
      tick(3);

      // Asynchronous reset at ack+2 of a 100-cycle delay.
      t = cyc;
      req = 2'b01;
      set_dly(100, 0);
      push(0, 2'b01, t + 1);
      tick();
      req = 2'b00;
      tick(2);
      chk("pre_reset_busy", {31'd0, busy}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("async_reset_busy", {31'd0, busy}, 32'd0);
      chk("async_reset_ack", {30'd0, ack}, 32'd0);
      chk("async_reset_done", {30'd0, done}, 32'd0);
      tick();
      reset = 1'b0;
      tick();
      t = cyc;
      req = 2'b11;
      set_dly(2, 2);
      push(0, 2'b01, t + 1);
      push(1, 2'b01, t + 3);
      tick();
      req = 2'b00;
      tick(4);

      chk("queue_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
